// File: rtl/mux2_1_sync.sv
// Registered 2:1 multiplexer with configurable data width and pipeline latency.
// The output register is the final pipeline stage; m and sel_q hold across bubbles.
module mux2_1_sync #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] m,
    output logic             out_valid,
    output logic             sel_q
);

    logic [WIDTH-1:0] pick_c;
    logic             sel_c;

    logic [WIDTH-1:0] last_data_c;
    logic             last_sel_c;
    logic             last_vld_c;

    // Selected word, zeroed when unqualified so idle X/Z operands never enter the pipe
    always_comb begin
        pick_c = '0;
        sel_c  = 1'b0;
        if (in_valid) begin
            pick_c = s ? x : y;
            sel_c  = s;
        end
    end

    generate
        if (LATENCY <= 1) begin : g_direct
            // Single-cycle latency: the output register samples the selection directly
            always_comb begin
                last_data_c = pick_c;
                last_sel_c  = sel_c;
                last_vld_c  = in_valid;
            end
        end else begin : g_pipe
            localparam int unsigned PIPE = LATENCY - 1;

            logic [WIDTH-1:0] data_q [PIPE];
            logic             sel_pq [PIPE];
            logic             vld_q  [PIPE];

            // Non-stalling delay line ahead of the output register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < PIPE; k++) begin
                        data_q[k] <= '0;
                        sel_pq[k] <= 1'b0;
                        vld_q[k]  <= 1'b0;
                    end
                end else begin
                    data_q[0] <= pick_c;
                    sel_pq[0] <= sel_c;
                    vld_q[0]  <= in_valid;
                    for (int unsigned k = 1; k < PIPE; k++) begin
                        data_q[k] <= data_q[k-1];
                        sel_pq[k] <= sel_pq[k-1];
                        vld_q[k]  <= vld_q[k-1];
                    end
                end
            end

            // Tap the last delay stage for the output register
            always_comb begin
                last_data_c = data_q[PIPE-1];
                last_sel_c  = sel_pq[PIPE-1];
                last_vld_c  = vld_q[PIPE-1];
            end
        end
    endgenerate

    // Output register: valid mirrors the final stage, data and select hold over bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m         <= '0;
            sel_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= last_vld_c;
            if (last_vld_c) begin
                m     <= last_data_c;
                sel_q <= last_sel_c;
            end
        end
    end

endmodule

// File: tb/tb_mux2_1_sync.sv
// Self-checking bench for mux2_1_sync: three instances (W1/L1, W8/L3, W8/L4) driven in lockstep,
// expected slots pushed to a scoreboard queue at drive time and read back LATENCY-1 edges later.
module tb_mux2_1_sync;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
        logic       sel;
    } slot_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;
    logic       s;
    logic       in_valid;

    logic [0:0] m1;
    logic [7:0] m3;
    logic [7:0] m4;
    logic       ov1, ov3, ov4;
    logic       sq1, sq3, sq4;

    slot_t      hist [$];
    logic [7:0] hm [3];
    logic       hs [3];
    logic       ev [3];
    int         lat_of [3];

    int n_assert = 0;
    int n_fail   = 0;

    mux2_1_sync #(.WIDTH(1), .LATENCY(1)) u_w1l1 (
        .clk(clk), .rst_n(rst_n), .x(x[0:0]), .y(y[0:0]), .s(s), .in_valid(in_valid),
        .m(m1), .out_valid(ov1), .sel_q(sq1)
    );

    mux2_1_sync #(.WIDTH(8), .LATENCY(3)) u_w8l3 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .s(s), .in_valid(in_valid),
        .m(m3), .out_valid(ov3), .sel_q(sq3)
    );

    mux2_1_sync #(.WIDTH(8), .LATENCY(4)) u_w8l4 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .s(s), .in_valid(in_valid),
        .m(m4), .out_valid(ov4), .sel_q(sq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the scoreboard at the edge, then compare all outputs
    task automatic cycle(input logic rn, input logic iv, input logic [7:0] xv,
                         input logic [7:0] yv, input logic sv);
        slot_t e;
        rst_n    = rn;
        in_valid = iv;
        x        = xv;
        y        = yv;
        s        = sv;
        @(posedge clk);
        if (!rn) begin
            hist.delete();
            repeat (3) hist.push_back('0);
            for (int d = 0; d < 3; d++) begin
                hm[d] = 8'h00;
                hs[d] = 1'b0;
                ev[d] = 1'b0;
            end
        end else begin
            if (iv) begin
                e.vld  = 1'b1;
                e.data = sv ? xv : yv;
                e.sel  = sv;
            end else begin
                e = '0;
            end
            hist.push_back(e);
            while (hist.size() > 8) void'(hist.pop_front());
            for (int d = 0; d < 3; d++) begin
                e     = hist[hist.size() - lat_of[d]];
                ev[d] = e.vld;
                if (e.vld) begin
                    hm[d] = e.data;
                    hs[d] = e.sel;
                end
            end
        end
        #1;
        check("L1_out_valid", 8'(ov1), 8'(ev[0]));
        check("L1_m",         8'(m1),  hm[0] & 8'h01);
        check("L1_sel_q",     8'(sq1), 8'(hs[0]));
        check("L3_out_valid", 8'(ov3), 8'(ev[1]));
        check("L3_m",         m3,      hm[1]);
        check("L3_sel_q",     8'(sq3), 8'(hs[1]));
        check("L4_out_valid", 8'(ov4), 8'(ev[2]));
        check("L4_m",         m4,      hm[2]);
        check("L4_sel_q",     8'(sq4), 8'(hs[2]));
    endtask

    initial begin
        lat_of[0] = 1;
        lat_of[1] = 3;
        lat_of[2] = 4;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 8'h00;
        y        = 8'h00;
        s        = 1'b0;

        // Reset held 3 cycles with a valid-looking input, then release with a bubble
        repeat (3) cycle(1'b0, 1'b1, 8'h01, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b1);

        // Select toggling on back-to-back valid inputs (bit 0: x=1, y=0 for the 1-bit instance)
        cycle(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
        cycle(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0);
        cycle(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Bubble hold: idle operands (including unknowns) must not reach m
        cycle(1'b1, 1'b1, 8'h0F, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        cycle(1'b1, 1'b0, 8'hxx, 8'hxx, 1'bx);
        cycle(1'b1, 1'b1, 8'h00, 8'h11, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);

        // Mid-flight reset discards all in-flight results
        cycle(1'b1, 1'b1, 8'h81, 8'h99, 1'b1);
        cycle(1'b1, 1'b1, 8'h42, 8'h99, 1'b0);
        cycle(1'b1, 1'b1, 8'h24, 8'h99, 1'b1);
        cycle(1'b0, 1'b1, 8'h77, 8'h66, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'hC3, 8'h5A, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // All eight x/y/s combinations, operands replicated across the byte
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = 3'(i);
            cycle(1'b1, 1'b1, {8{c[2]}}, {8{c[1]}}, c[0]);
        end
        repeat (4) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
